// File: rtl/serpent_keysched_ctrl.sv
// Serpent key-schedule sequencer: loads the padded key into the prekey store,
// steps 132 prekey generations and issues the 33 round-key RAM writes.
module serpent_keysched_ctrl #(
  parameter int NUM_PREKEYS = 132,
  parameter int NUM_RKEYS   = 33,
  parameter int IDX_W       = 8,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_ready,
  output logic              o_store_rst,
  output logic              o_gen_valid,
  output logic [IDX_W-1:0]  o_prekey_idx,
  output logic              o_rk_we,
  output logic [ADDR_W-1:0] o_rk_addr,
  output logic [2:0]        o_sbox_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_keys_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PREKEYS - 1);
  localparam logic [IDX_W-1:0] DRAIN_IDX = IDX_W'(NUM_RKEYS * 4);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_FOUR  = IDX_W'(4);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                r_keys_valid;
  logic                w_keys_valid_nxt;
  logic [ADDR_W-1:0]   r_rk_addr_hold;
  logic [ADDR_W-1:0]   w_rk_addr_calc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_keys_valid   <= 1'b0;
      r_rk_addr_hold <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_keys_valid <= w_keys_valid_nxt;
      // Address and S-box select keep showing the last write between pulses
      if (o_rk_we) begin
        r_rk_addr_hold <= w_rk_addr_calc;
      end else begin
        r_rk_addr_hold <= r_rk_addr_hold;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_keys_valid_nxt = r_keys_valid;
    case (r_state)
      S_IDLE: begin
        if (i_start && o_ready) begin
          w_state_nxt      = S_GEN;
          w_idx_nxt        = '0;
          w_keys_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GEN: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DRAIN;
          w_idx_nxt   = DRAIN_IDX;
        end else begin
          w_idx_nxt = r_idx + IDX_ONE;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt      = S_IDLE;
        w_keys_valid_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Round key j is complete once prekey 4j+3 sits in the store, i.e. when idx = 4(j+1)
  assign w_rk_addr_calc = ADDR_W'((r_idx >> 2) - IDX_ONE);

  always_comb begin
    o_ready      = 1'b0;
    o_store_rst  = 1'b0;
    o_gen_valid  = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_rk_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready     = 1'b1;
        o_store_rst = 1'b1;
      end
      S_GEN: begin
        o_gen_valid = 1'b1;
        o_busy      = 1'b1;
        o_rk_we     = (r_idx >= IDX_FOUR) && (r_idx[1:0] == 2'b00);
      end
      S_DRAIN: begin
        o_busy  = 1'b1;
        o_rk_we = (r_idx >= IDX_FOUR) && (r_idx[1:0] == 2'b00);
      end
      S_DONE: begin
        o_done      = 1'b1;
        o_store_rst = 1'b1;
      end
      default: begin
        o_store_rst = 1'b1;
      end
    endcase
    o_prekey_idx = r_idx;
    o_keys_valid = r_keys_valid;
    if (o_rk_we) begin
      o_rk_addr = w_rk_addr_calc;
    end else begin
      o_rk_addr = r_rk_addr_hold;
    end
    o_sbox_sel = 3'd3 - o_rk_addr[2:0];
  end

endmodule
